// File: rtl/conv_window_controller.sv
// Raster-stream sequencer for a KxK Line_Buffer chain: drives the shift strobe and data,
// tracks pixel position and flags stride-aligned valid window positions.
module conv_window_controller #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned ROW_SIZE    = 5,
  parameter int unsigned COL_SIZE    = 5,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        buf_shift,
  output logic [DATA_WIDTH-1:0]       buf_data,
  output logic                        window_valid,
  output logic [$clog2(COL_SIZE)-1:0] out_row,
  output logic [$clog2(ROW_SIZE)-1:0] out_col,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int unsigned RW = $clog2(COL_SIZE);
  localparam int unsigned CW = $clog2(ROW_SIZE);
  localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(COL_SIZE - 1);
  localparam logic [CW-1:0] K_COL    = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] K_ROW    = RW'(KERNEL_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          done_cnt;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [PW-1:0] col_ph;
  logic [PW-1:0] row_ph;
  logic [CW-1:0] oc_cnt;
  logic [RW-1:0] or_cnt;

  logic          win_pend;
  logic [RW-1:0] pend_row;
  logic [CW-1:0] pend_col;

  logic accept;
  logic last_pix;
  logic fill_pix;
  logic hit;

  assign in_ready = (state == S_FILL) || (state == S_ACTIVE);
  assign accept   = in_valid && in_ready;
  assign last_pix = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
  assign fill_pix = (col_cnt == K_COL) && (row_cnt == K_ROW);
  // Phase counters stay at 0 until the kernel fits, so phase 0 marks stride alignment.
  assign hit      = accept && (row_cnt >= K_ROW) && (col_cnt >= K_COL) &&
                    (row_ph == '0) && (col_ph == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      done_cnt <= 1'b0;
    end else begin
      state    <= next_state;
      done_cnt <= (state == S_DONE) ? ~done_cnt : 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FILL;
      S_FILL: begin
        if (accept && last_pix)      next_state = S_DONE;
        else if (accept && fill_pix) next_state = S_ACTIVE;
      end
      S_ACTIVE: if (accept && last_pix) next_state = S_DONE;
      S_DONE:   if (done_cnt) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Position, stride phase and output-index counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
      oc_cnt  <= '0;
      or_cnt  <= '0;
    end else if ((state == S_IDLE) && start) begin
      col_cnt <= '0;
      row_cnt <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
      oc_cnt  <= '0;
      or_cnt  <= '0;
    end else if (accept) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        col_ph  <= '0;
        oc_cnt  <= '0;
        if (row_cnt == ROW_LAST) begin
          row_cnt <= '0;
          row_ph  <= '0;
          or_cnt  <= '0;
        end else begin
          row_cnt <= row_cnt + RW'(1);
          if (row_cnt >= K_ROW) begin
            if (row_ph == PH_LAST) begin
              row_ph <= '0;
              or_cnt <= or_cnt + RW'(1);
            end else begin
              row_ph <= row_ph + PW'(1);
            end
          end
        end
      end else begin
        col_cnt <= col_cnt + CW'(1);
        if (col_cnt >= K_COL) begin
          if (col_ph == PH_LAST) begin
            col_ph <= '0;
            oc_cnt <= oc_cnt + CW'(1);
          end else begin
            col_ph <= col_ph + PW'(1);
          end
        end
      end
    end
  end

  // Shift strobe at the accept edge; window flag one edge later so the chain has captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_shift    <= 1'b0;
      buf_data     <= '0;
      win_pend     <= 1'b0;
      pend_row     <= '0;
      pend_col     <= '0;
      window_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      buf_shift    <= accept;
      if (accept) buf_data <= in_data;
      win_pend     <= hit;
      if (hit) begin
        pend_row <= or_cnt;
        pend_col <= oc_cnt;
      end
      window_valid <= win_pend;
      if (win_pend) begin
        out_row <= pend_row;
        out_col <= pend_col;
      end
      busy         <= (next_state != S_IDLE);
      frame_done   <= (state == S_DONE) && !done_cnt;
    end
  end

endmodule

// File: tb/tb_conv_window_controller.sv
// Directed bench: two controllers (stride 1 and stride 2, 5x5 image, K=3) share one stimulus.
module tb_conv_window_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready1, buf_shift1, window_valid1, busy1, frame_done1;
  logic [7:0] buf_data1;
  logic [2:0] out_row1, out_col1;
  logic       in_ready2, buf_shift2, window_valid2, busy2, frame_done2;
  logic [7:0] buf_data2;
  logic [2:0] out_row2, out_col2;

  conv_window_controller #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .buf_shift(buf_shift1), .buf_data(buf_data1),
    .window_valid(window_valid1), .out_row(out_row1), .out_col(out_col1),
    .busy(busy1), .frame_done(frame_done1));

  conv_window_controller #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .buf_shift(buf_shift2), .buf_data(buf_data2),
    .window_valid(window_valid2), .out_row(out_row2), .out_col(out_col2),
    .busy(busy2), .frame_done(frame_done2));

  always #5 clock = ~clock;

  typedef struct {int cyc; int row; int col;} ev_t;
  typedef struct {int cyc; int data;} sh_t;
  typedef struct {int pix; bit w1; int r1; int c1; bit w2; int r2; int c2;} vec_t;

  ev_t  ev1[$], ev2[$];
  sh_t  sh1[$];
  int   sh2_cnt;
  int   acc[$];
  int   fd1, fd2;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[9];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (window_valid1) ev1.push_back('{cyc, int'(out_row1), int'(out_col1)});
    if (window_valid2) ev2.push_back('{cyc, int'(out_row2), int'(out_col2)});
    if (buf_shift1) sh1.push_back('{cyc, int'(buf_data1)});
    if (buf_shift2) sh2_cnt++;
    if (in_valid && in_ready1) acc.push_back(cyc);
    if (frame_done1) fd1++;
    if (frame_done2) fd2++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    ev1.delete(); ev2.delete(); sh1.delete(); acc.delete();
    sh2_cnt = 0; fd1 = 0; fd2 = 0;
  endtask

  task automatic send(input int v);
    int n;
    in_valid = 1'b1;
    in_data  = 8'(v);
    n = 0;
    while (!in_ready1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) chk("send_ready_timeout", n, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},     int'(in_ready1) + int'(in_ready2), 0);
    chk({tag, "_buf_shift"},    int'(buf_shift1) + int'(buf_shift2), 0);
    chk({tag, "_buf_data"},     int'(buf_data1) + int'(buf_data2), 0);
    chk({tag, "_window_valid"}, int'(window_valid1) + int'(window_valid2), 0);
    chk({tag, "_out_pos"},      int'(out_row1) + int'(out_col1) + int'(out_row2) + int'(out_col2), 0);
    chk({tag, "_busy"},         int'(busy1) + int'(busy2), 0);
    chk({tag, "_frame_done"},   int'(frame_done1) + int'(frame_done2), 0);
  endtask

  task automatic analyze(input int base);
    bit w1, w2, f;
    int r1, c1, r2, c2, fr, fc;
    chk("accept_count", acc.size(), 25);
    chk("shift1_count", sh1.size(), 25);
    chk("shift2_count", sh2_cnt, 25);
    for (int i = 0; i < sh1.size() && i < acc.size(); i++) begin
      chk($sformatf("shift_time_p%0d", i + 1), sh1[i].cyc, acc[i] + 1);
      chk($sformatf("shift_data_p%0d", i + 1), sh1[i].data, base + i + 1);
    end
    for (int i = 0; i < acc.size() && i < 25; i++) begin
      w1 = 0; w2 = 0; r1 = 0; c1 = 0; r2 = 0; c2 = 0;
      for (int k = 0; k < 9; k++)
        if (tbl[k].pix == i + 1) begin
          w1 = tbl[k].w1; r1 = tbl[k].r1; c1 = tbl[k].c1;
          w2 = tbl[k].w2; r2 = tbl[k].r2; c2 = tbl[k].c2;
        end
      f = 0; fr = 0; fc = 0;
      foreach (ev1[j]) if (ev1[j].cyc == acc[i] + 2) begin f = 1; fr = ev1[j].row; fc = ev1[j].col; end
      chk($sformatf("s1_win_p%0d", i + 1), int'(f), int'(w1));
      if (w1) chk($sformatf("s1_pos_p%0d", i + 1), fr * 16 + fc, r1 * 16 + c1);
      f = 0; fr = 0; fc = 0;
      foreach (ev2[j]) if (ev2[j].cyc == acc[i] + 2) begin f = 1; fr = ev2[j].row; fc = ev2[j].col; end
      chk($sformatf("s2_win_p%0d", i + 1), int'(f), int'(w2));
      if (w2) chk($sformatf("s2_pos_p%0d", i + 1), fr * 16 + fc, r2 * 16 + c2);
    end
    chk("s1_window_total", ev1.size(), 9);
    chk("s2_window_total", ev2.size(), 4);
    chk("s1_frame_done_count", fd1, 1);
    chk("s2_frame_done_count", fd2, 1);
  endtask

  task automatic run_frame(input int base, input bit gaps, input bit mid_start);
    int n;
    clear_mon();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int p = 1; p <= 25; p++) begin
      send(base + p);
      if (gaps) begin
        @(posedge clock); #1;
      end
      if (mid_start && p == 15) begin
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
      end
    end
    n = 0;
    while (fd1 == 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    analyze(base);
    chk("after_frame_in_ready", int'(in_ready1) + int'(in_ready2), 0);
    chk("after_frame_busy", int'(busy1) + int'(busy2), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d expected_finish_before=50000", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{13, 1'b1, 0, 0, 1'b1, 0, 0};
    tbl[1] = '{14, 1'b1, 0, 1, 1'b0, 0, 0};
    tbl[2] = '{15, 1'b1, 0, 2, 1'b1, 0, 1};
    tbl[3] = '{18, 1'b1, 1, 0, 1'b0, 0, 0};
    tbl[4] = '{19, 1'b1, 1, 1, 1'b0, 0, 0};
    tbl[5] = '{20, 1'b1, 1, 2, 1'b0, 0, 0};
    tbl[6] = '{23, 1'b1, 2, 0, 1'b1, 1, 0};
    tbl[7] = '{24, 1'b1, 2, 1, 1'b0, 0, 0};
    tbl[8] = '{25, 1'b1, 2, 2, 1'b1, 1, 1};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    clear_mon();
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Back-to-back pixels, then the same frame with a stall after every pixel.
    run_frame(0, 1'b0, 1'b0);
    run_frame(32, 1'b1, 1'b0);

    // in_valid in IDLE must not be accepted; start mid-frame must be ignored.
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_in_ready", int'(in_ready1) + int'(in_ready2), 0);
    end
    @(posedge clock); #1;
    chk("idle_no_shift", sh1.size() + sh2_cnt, 0);
    in_valid = 1'b0;
    run_frame(64, 1'b0, 1'b1);

    // Reset mid-frame right after pixel 10 has been shifted out.
    clear_mon();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int p = 1; p <= 10; p++) send(100 + p);
    chk("pre_reset_shift", int'(buf_shift1), 1);
    chk("pre_reset_data", int'(buf_data1), 110);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midreset_no_done", fd1 + fd2, 0);
    run_frame(128, 1'b0, 1'b0);

    // Two frames, second start in the cycle right after frame_done.
    run_frame(160, 1'b0, 1'b0);
    run_frame(192, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
